// File: rtl/nt_chain_monitor.sv
// Multi-channel Nt-node monitor: registered NAND/NOR cone per channel with a delayed A path,
// plus a shared saturating activation counter and threshold flag. Build option: NT_MON_STICKY_EN.
module nt_chain_monitor #(
  parameter int CH    = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             I1470,
  input  logic             I1477,
  input  logic [CH-1:0]    in_a,
  input  logic [CH-1:0]    in_b,
  input  logic [CH-1:0]    in_c,
  input  logic [CH-1:0]    in_d,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] thr,
  output logic [CH-1:0]    out_q,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             hit_sat,
  output logic             thr_flag
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CH-1:0][DEPTH-1:0] a_pipe;
  logic [CH-1:0]            b_r;
  logic [CH-1:0]            d_r;
  logic [CH-1:0]            a_l;
  logic [CH-1:0]            n;
  logic [CH-1:0]            m;
  logic [CH-1:0]            p;
  logic                     active;
  logic [CNT_W-1:0]         cnt_next;
  logic                     flag_hit;
  logic                     sat_hit;

  // The cone is plain bitwise logic; only the A tap needs to be pulled out of each pipe.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      a_l[i] = a_pipe[i][DEPTH-1];
    end
    n = ~(in_c & d_r);
    m = ~(b_r | n);
    p = ~(~a_l & m);
  end

  // Several channels active in one cycle still count as a single activation.
  assign active = ~(&out_q);

  always_comb begin
    cnt_next = hit_cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (en && active && (hit_cnt != CNT_MAX)) begin
      cnt_next = hit_cnt + CNT_ONE;
    end
  end

  // Flags look at the next-state count so they rise on the same edge as hit_cnt.
  assign flag_hit = (thr != '0) && (cnt_next >= thr);
  assign sat_hit  = (cnt_next == CNT_MAX);

  // NOTE: every register here uses non-blocking assignment so all flops sample
  // pre-edge values; blocking assignments would let the A pipe collapse into one stage.
  always_ff @(posedge I1470) begin
    if (I1477) begin
      // NOTE: the pipes are ordinary flops (not memory), so they are cleared with the rest.
      a_pipe   <= '0;
      b_r      <= '0;
      d_r      <= '0;
      out_q    <= '0;
      hit_cnt  <= '0;
      hit_sat  <= 1'b0;
      thr_flag <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        a_pipe[i][0] <= in_a[i];
        for (int s = 1; s < DEPTH; s++) begin
          a_pipe[i][s] <= a_pipe[i][s-1];
        end
      end
      b_r     <= in_b;
      d_r     <= in_d;
      out_q   <= p;
      hit_cnt <= cnt_next;
`ifdef NT_MON_STICKY_EN
      hit_sat  <= !clr && (hit_sat  || sat_hit);
      thr_flag <= !clr && (thr_flag || flag_hit);
`else
      hit_sat  <= sat_hit;
      thr_flag <= flag_hit;
`endif
    end
  end

endmodule

// File: doc/nt_chain_monitor.md
# nt_chain_monitor

Parametrised multi-channel successor to the single-bit Nt-node subcircuit. Each channel keeps the same registered NAND/NOR cone, now with a configurable delay depth on the A path. A shared, saturating activation counter and a threshold flag are added so the bench can measure how often rare-node activations occur. The block sits in the trojan-detection benchmark flow as a drop-in monitor over `CH` subcircuit instances.

## Interface
- `CH`, 4: number of independent channels (≥1).
- `DEPTH`, 2: register stages on each A input (≥1).
- `CNT_W`, 8: width of the activation counter and the threshold (≥2).

- `I1470`  in  1  clock; every flop is rising-edge.
- `I1477`  in  1  reset; synchronous, active-high, one clock, one reset. It clears every flop to 0.
- `in_a`  in  CH  A inputs, one bit per channel.
- `in_b`  in  CH  B inputs.
- `in_c`  in  CH  C inputs, used combinationally.
- `in_d`  in  CH  D inputs.
- `en`  in  1  counter enable.
- `clr`  in  1  synchronous clear of the counter, `hit_sat` and `thr_flag`.
- `thr`  in  CNT_W  activation threshold; 0 disables the flag.
- `out_q`  out  CH  registered channel outputs.
- `hit_cnt`  out  CNT_W  count of cycles in which any channel was active.
- `hit_sat`  out  1  counter has reached its all-ones value.
- `thr_flag`  out  1  threshold reached.

## Operation
- Per-channel datapath for channel i:
  - `a_pipe[i]`: a shift chain of DEPTH flops fed by `in_a[i]`; its last stage is `a_l`.
  - `b_r` and `d_r`: single flops on `in_b[i]` and `in_d[i]`.
  - `n = ~(in_c[i] & d_r)`
  - `m = ~(b_r | n)`
  - `p = ~(~a_l & m)`
  - `out_q[i] <= p`
- A channel is active when `out_q[i] == 0`. This happens only when `a_l = 0`, `b_r = 0`, `in_c = 1` and `d_r = 1` in the previous cycle. It is the rare condition being monitored.
- Counter update, evaluated each cycle. Priority: reset > `clr` > count.
  - If `en` is high and any bit of `out_q` is 0, `hit_cnt` increments by 1.
  - The counter saturates at 2^CNT_W − 1 and never wraps.
  - `hit_sat` is registered and goes high in the same cycle `hit_cnt` reaches all-ones.
  - Several active channels in one cycle add only 1.
- Threshold: the flag asserts when `thr != 0` and the next-state `hit_cnt >= thr`. It is registered, so it rises on the same edge `hit_cnt` reaches `thr`.
- `clr` together with an active count: the clear wins and `hit_cnt` becomes 0.
- `thr` may change at any time. Comparison always uses the current `thr`.

## Timing
- Reset values: `out_q = 0`, `hit_cnt = 0`, `hit_sat = 0`, `thr_flag = 0`, and all pipe flops 0.
- First cycle after reset release: `a_l = 0` and `n = 1`, so `m = 0`, `p = 1`, and `out_q` goes to all-ones.
- Because `out_q` is 0 at that first edge, a channel reads as active for that cycle. The counter therefore counts 1 if `en` is high on the first post-reset cycle. The bench holds `en` low there.
- Latency to `out_q`:
  - `in_a`: DEPTH + 1 cycles.
  - `in_b` and `in_d`: 2 cycles.
  - `in_c`: 1 cycle.
- `out_q` to `hit_cnt`: 1 cycle. `hit_cnt` to `thr_flag`: same edge.
- Reset asserted mid-run clears all state on the next edge, including counts already in progress.

## Configuration
- Macro: `NT_MON_STICKY_EN`.
- Defined:
  - `thr_flag` is sticky. Once set, it stays high until reset or `clr`, even if `thr` is raised later.
  - `hit_sat` is sticky likewise.
- Undefined:
  - `thr_flag` is recomputed every cycle as `(thr != 0) && (hit_cnt >= thr)`, still registered.
  - Raising `thr` above `hit_cnt` drops the flag on the next edge.
  - `hit_sat` is also recomputed every cycle as `hit_cnt == all-ones`, still registered, so it drops after `clr`.

## Test plan
- Reset values: hold `I1477` high for 3 cycles, then release with all inputs 0 → `out_q = 0`, `hit_cnt = 0`, `hit_sat = 0`, `thr_flag = 0` during reset; `out_q = 4'hF` one cycle after release.
- Single activation, CH = 4 and DEPTH = 2, `en` high: drive channel 2 with `in_a = 0`, `in_b = 0`, `in_d = 1` for 3 cycles, then pulse `in_c = 1` → `out_q = 4'b1011` for exactly one cycle and `hit_cnt` goes 0→1.
- Multi-channel: all 4 channels active for 5 cycles, `en = 1` → `hit_cnt = 5`, not 20.
- Saturation, CNT_W = 4: continuous activation for 20 cycles → `hit_cnt` stops at 15 and `hit_sat = 1`; then pulse `clr` with activation still present → `hit_cnt = 0` for one cycle and `hit_sat = 0`.
- Threshold, `thr = 3`: the third counted cycle sets `thr_flag` on the same edge. Then set `thr = 10` → with `NT_MON_STICKY_EN` defined the flag stays 1; undefined, it drops next cycle. `thr = 0` never sets the flag.
- Reset mid-run: assert `I1477` while `hit_cnt = 7` and `en = 1` → next edge gives `hit_cnt = 0`, `out_q = 0` and `thr_flag = 0`, regardless of `clr`.
